// File: rtl/egress_port.sv
// egress_port: output-port stage of a small crossbar switch.
//
// A scheduler grant (en/sel) is registered into a capture stage whose timing
// lines up with the one-cycle read latency of the input FIFOs. The captured
// word is pushed into a local DEPTH-word FIFO, or dropped when the grant
// selects no input or the FIFO is full with no pop this cycle. The head word is
// presented on dout and leaves on dout_valid & out_ready.
//
// Ports
//   clk         sole clock, rising edge
//   rst_n       asynchronous active-low reset
//   en          one-cycle grant pulse from the scheduler
//   sel         granted input: 01=din1, 10=din2, 11=din3, 00=none
//   din1..din3  input-FIFO read data, valid the cycle after the grant
//   out_ready   downstream accepts dout this cycle
//   dout        head-of-FIFO word (zero when empty)
//   dout_valid  FIFO not empty
//   busy        occupancy >= AFULL; scheduler must withhold grants
//   level       current occupancy (0..DEPTH)
//   word_cnt    words accepted, saturating
//   drop_cnt    words dropped, saturating
//
// DEPTH must be a power of two (4..64) so the pointers wrap naturally.

module egress_port #(
    parameter int DEPTH = 8,
    parameter int AFULL = DEPTH - 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     en,
    input  logic [1:0]               sel,
    input  logic [31:0]              din1,
    input  logic [31:0]              din2,
    input  logic [31:0]              din3,
    input  logic                     out_ready,
    output logic [31:0]              dout,
    output logic                     dout_valid,
    output logic                     busy,
    output logic [$clog2(DEPTH):0]   level,
    output logic [15:0]              word_cnt,
    output logic [7:0]               drop_cnt
);

    localparam int PW = $clog2(DEPTH);
    localparam int LW = PW + 1;
    localparam logic [LW-1:0] DEPTH_L = LW'(DEPTH);
    localparam logic [LW-1:0] AFULL_L = LW'(AFULL);

    logic          cap_v_q;
    logic [1:0]    cap_sel_q;
    logic [31:0]   mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [LW-1:0] level_q, level_d;
    logic [15:0]   word_cnt_q, word_cnt_d;
    logic [7:0]    drop_cnt_q, drop_cnt_d;

    logic [31:0]   push_word;
    logic          pop;
    logic          full;
    logic          push;
    logic          drop;

    always_comb begin
        push_word = 32'h0;
        case (cap_sel_q)
            2'b01:   push_word = din1;
            2'b10:   push_word = din2;
            2'b11:   push_word = din3;
            default: push_word = 32'h0;
        endcase
    end

    assign dout_valid = (level_q != '0);
    assign pop        = dout_valid && out_ready;
    assign full       = (level_q == DEPTH_L);
    // A full FIFO still accepts when the head leaves on the same edge: the
    // write lands in the slot being vacated.
    assign push       = cap_v_q && (cap_sel_q != 2'b00) && (!full || pop);
    assign drop       = cap_v_q && !push;

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        level_d    = level_q;
        word_cnt_d = word_cnt_q;
        drop_cnt_d = drop_cnt_q;

        if (push) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end

        case ({push, pop})
            2'b10:   level_d = level_q + LW'(1);
            2'b01:   level_d = level_q - LW'(1);
            default: level_d = level_q;
        endcase

        if (push && (word_cnt_q != 16'hFFFF)) begin
            word_cnt_d = word_cnt_q + 16'd1;
        end
        if (drop && (drop_cnt_q != 8'hFF)) begin
            drop_cnt_d = drop_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cap_v_q    <= 1'b0;
            cap_sel_q  <= 2'b00;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            word_cnt_q <= 16'h0;
            drop_cnt_q <= 8'h0;
        end else begin
            cap_v_q    <= en;
            cap_sel_q  <= sel;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
            word_cnt_q <= word_cnt_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    // Storage needs no reset: occupancy alone decides what is visible.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= push_word;
        end
    end

    // Gate the head word so dout reads zero whenever the FIFO is empty.
    assign dout     = dout_valid ? mem_q[rd_ptr_q] : 32'h0;
    assign busy     = (level_q >= AFULL_L);
    assign level    = level_q;
    assign word_cnt = word_cnt_q;
    assign drop_cnt = drop_cnt_q;

endmodule

// File: tb/tb_egress_port.sv
module tb_egress_port;

    localparam int DEPTH = 8;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en;
    logic [1:0]  sel;
    logic [31:0] din1, din2, din3;
    logic        out_ready;
    logic [31:0] dout;
    logic        dout_valid;
    logic        busy;
    logic [$clog2(DEPTH):0] level;
    logic [15:0] word_cnt;
    logic [7:0]  drop_cnt;

    int          n_vec = 0;
    int          n_err = 0;
    int          exp_words = 0;
    int          exp_drops = 0;
    logic [31:0] sb_q [$];

    egress_port #(.DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en),
        .sel        (sel),
        .din1       (din1),
        .din2       (din2),
        .din3       (din3),
        .out_ready  (out_ready),
        .dout       (dout),
        .dout_valid (dout_valid),
        .busy       (busy),
        .level      (level),
        .word_cnt   (word_cnt),
        .drop_cnt   (drop_cnt)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One grant: en/sel in the first cycle, the selected input's data in the
    // second (capture) cycle. Unselected inputs carry values that differ from
    // the word so a wrong mux choice is visible.
    task automatic grant(input logic [1:0] s, input logic [31:0] data, input bit acc,
                         input bit rdy0, input bit rdy1);
        en = 1'b1;
        sel = s;
        out_ready = rdy0;
        tick();
        en = 1'b0;
        sel = 2'b00;
        out_ready = rdy1;
        din1 = ~data;
        din2 = data ^ 32'h5A5A_5A5A;
        din3 = data + 32'h1000_0000;
        case (s)
            2'b01:   din1 = data;
            2'b10:   din2 = data;
            2'b11:   din3 = data;
            default: ;
        endcase
        if (acc) begin
            sb_q.push_back(data);
            exp_words++;
        end else begin
            exp_drops++;
        end
        tick();
    endtask

    task automatic drain(input string tag);
        out_ready = 1'b1;
        for (int k = 0; k < 100 && dout_valid; k++) tick();
        out_ready = 1'b0;
        chk(tag, 32'(dout_valid), 32'h0);
        chk({tag, "_sb_left"}, 32'(sb_q.size()), 32'h0);
    endtask

    initial begin
        rst_n = 1'b0;
        en = 1'b0;
        sel = 2'b00;
        din1 = 32'h0;
        din2 = 32'h0;
        din3 = 32'h0;
        out_ready = 1'b0;

        // Output monitor: every word leaving the port must match the head of
        // the scoreboard.
        fork
            forever begin
                @(negedge clk);
                if (rst_n && dout_valid && out_ready) begin
                    n_vec++;
                    assert (sb_q.size() != 0) else begin
                        n_err++;
                        $error("FAIL sb_underflow observed=%0h expected=none", dout);
                    end
                    if (sb_q.size() != 0) chk("dout_order", dout, sb_q.pop_front());
                end
            end
        join_none

        tick();
        tick();
        chk("rst_level", 32'(level), 32'h0);
        chk("rst_valid", 32'(dout_valid), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_wcnt", 32'(word_cnt), 32'h0);
        chk("rst_dcnt", 32'(drop_cnt), 32'h0);
        chk("rst_dout", dout, 32'h0);
        rst_n = 1'b1;
        tick();

        // Single word with two-cycle latency.
        en = 1'b1;
        sel = 2'b10;
        out_ready = 1'b1;
        sb_q.push_back(32'hA5A5_0002);
        exp_words++;
        tick();
        en = 1'b0;
        sel = 2'b00;
        din1 = 32'h1111_1111;
        din2 = 32'hA5A5_0002;
        din3 = 32'h3333_3333;
        chk("lat_valid_1", 32'(dout_valid), 32'h0);
        tick();
        chk("lat_valid_2", 32'(dout_valid), 32'h1);
        chk("lat_dout", dout, 32'hA5A5_0002);
        tick();
        chk("single_empty", 32'(dout_valid), 32'h0);
        chk("single_wcnt", 32'(word_cnt), 32'(exp_words));

        // Fill under backpressure, busy threshold, overflow drop.
        for (int i = 1; i <= 8; i++) begin
            grant(2'b01, 32'(i), 1'b1, 1'b0, 1'b0);
            chk("fill_level", 32'(level), 32'(i));
            chk("fill_busy", 32'(busy), 32'(i >= 6));
        end
        grant(2'b01, 32'h9, 1'b0, 1'b0, 1'b0);
        chk("ovf_dcnt", 32'(drop_cnt), 32'(exp_drops));
        chk("ovf_dout", dout, 32'h1);
        chk("ovf_level", 32'(level), 32'h8);

        // Full FIFO with pop on the push edge.
        grant(2'b11, 32'h99, 1'b1, 1'b0, 1'b1);
        chk("fullpop_level", 32'(level), 32'h8);
        chk("fullpop_dcnt", 32'(drop_cnt), 32'(exp_drops));
        drain("fullpop_drain");
        chk("fullpop_wcnt", 32'(word_cnt), 32'(exp_words));

        // Null select.
        grant(2'b00, 32'h0, 1'b0, 1'b0, 1'b0);
        chk("null_level", 32'(level), 32'h0);
        chk("null_dcnt", 32'(drop_cnt), 32'(exp_drops));
        chk("null_wcnt", 32'(word_cnt), 32'(exp_words));

        // Wrap and ordering with random backpressure, scheduler honouring busy.
        for (int i = 0; i < 20; i++) begin
            for (int k = 0; k < 200 && busy; k++) begin
                out_ready = 1'($urandom_range(0, 1));
                tick();
            end
            chk("wrap_busy_timeout", 32'(busy), 32'h0);
            grant(2'((i % 3) + 1), 32'(i), 1'b1,
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end
        drain("wrap_drain");
        chk("wrap_wcnt", 32'(word_cnt), 32'(exp_words));
        chk("wrap_dcnt", 32'(drop_cnt), 32'(exp_drops));

        // Reset mid-operation with a grant pending.
        for (int i = 0; i < 5; i++) grant(2'b01, 32'(100 + i), 1'b1, 1'b0, 1'b0);
        chk("prerst_level", 32'(level), 32'h5);
        en = 1'b1;
        sel = 2'b01;
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        en = 1'b0;
        sel = 2'b00;
        din1 = 32'hDEAD_BEEF;
        sb_q.delete();
        exp_words = 0;
        exp_drops = 0;
        chk("midrst_level", 32'(level), 32'h0);
        chk("midrst_valid", 32'(dout_valid), 32'h0);
        chk("midrst_wcnt", 32'(word_cnt), 32'h0);
        chk("midrst_dcnt", 32'(drop_cnt), 32'h0);
        chk("midrst_dout", dout, 32'h0);
        tick();
        tick();
        chk("postrst_level", 32'(level), 32'h0);
        chk("postrst_wcnt", 32'(word_cnt), 32'h0);

        // Grant on the first edge after reset release.
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        grant(2'b10, 32'hC0DE_0031, 1'b1, 1'b0, 1'b0);
        chk("first_edge_level", 32'(level), 32'h1);
        chk("first_edge_wcnt", 32'(word_cnt), 32'(exp_words));

        // Drop counter saturation via back-to-back null grants.
        en = 1'b1;
        sel = 2'b00;
        repeat (260) tick();
        en = 1'b0;
        tick();
        tick();
        chk("dcnt_sat", 32'(drop_cnt), 32'hFF);
        chk("sat_wcnt", 32'(word_cnt), 32'(exp_words));
        chk("sat_level", 32'(level), 32'h1);
        drain("final_drain");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/egress_port.md
EGRESS_PORT -- requirements
Module: egress_port

Interface
REQ-001 SHALL have parameter DEPTH, default 8, FIFO depth in 32-bit words (power of 2, 4..64).
REQ-002 SHALL have parameter AFULL, default DEPTH-2, occupancy at which busy asserts.
REQ-003 SHALL have port clk  input  1  sole clock, all state on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 SHALL have port en  input  1  grant from scheduler for this output port, one-cycle pulse.
REQ-006 SHALL have port sel  input  2  granted input: 01=in1, 10=in2, 11=in3, 00=none.
REQ-007 SHALL have port din1/din2/din3  input  32 each  input-FIFO read data, valid 1 cycle after rdreq/en.
REQ-008 SHALL have port out_ready  input  1  downstream sink accepts dout this cycle.
REQ-009 SHALL have port dout  output  32  head-of-FIFO word.
REQ-010 SHALL have port dout_valid  output  1  dout holds a valid word.
REQ-011 SHALL have port busy  output  1  occupancy >= AFULL; scheduler must withhold grants.
REQ-012 SHALL have port level  output  $clog2(DEPTH)+1  current FIFO occupancy.
REQ-013 SHALL have port word_cnt  output  16  words accepted, saturating at 16'hFFFF.
REQ-014 SHALL have port drop_cnt  output  8  words dropped (full or sel=00), saturating at 8'hFF.

Function
REQ-015 SHALL register en and sel into a capture stage (cap_v, cap_sel) every cycle; the mux matches FIFO read latency of 1.
REQ-016 SHALL, when cap_v=1, select din1/din2/din3 for cap_sel 01/10/11 as the push word.
REQ-017 SHALL treat cap_v=1 with cap_sel=00 as a drop: no push, drop_cnt+1.
REQ-018 SHALL push when cap_v=1, cap_sel!=00, and (level<DEPTH or pop this cycle); word_cnt+1.
REQ-019 SHALL drop when cap_v=1, cap_sel!=00, level==DEPTH, no pop this cycle: no push, drop_cnt+1, stored data unchanged.
REQ-020 SHALL pop when dout_valid=1 and out_ready=1; dout advances to next word on the following edge.
REQ-021 SHALL keep dout_valid=1 exactly when level>0; dout stable while dout_valid=1 and out_ready=0.
REQ-022 SHALL, on simultaneous push and pop, leave level unchanged and preserve order (FIFO).
REQ-023 SHALL wrap read/write pointers modulo DEPTH without bubbles; full and empty distinguished by level.
REQ-024 SHALL assert busy combinationally from level (level >= AFULL), giving two cycles of margin for grants already in flight.
REQ-025 SHALL ignore out_ready when dout_valid=0 (no underflow, level never negative).
REQ-026 SHALL stop incrementing word_cnt at 16'hFFFF and drop_cnt at 8'hFF; no wrap.
REQ-027 SHALL have latency en -> dout_valid of 2 cycles when empty (capture edge, push edge).
REQ-028 SHALL not inspect word contents; a zero word is stored like any other.

Reset
REQ-029 SHALL, while rst_n=0, force cap_v=0, pointers=0, level=0, dout_valid=0, busy=0, word_cnt=0, drop_cnt=0, dout=0.
REQ-030 SHALL, on reset mid-packet, discard all stored and in-flight words with no partial push after release.
REQ-031 SHALL accept a grant on the first rising edge after rst_n deasserts.

Verification
REQ-032 Single word: en=1,sel=10,din2=32'hA5A5_0002 next cycle, out_ready=1 -> dout_valid=1 two cycles after en, dout=32'hA5A5_0002, word_cnt=1, then empty.
REQ-033 Fill/backpressure: out_ready=0, 8 grants sel=01 with din1=1..8 -> level=8, busy=1 from level 6; 9th grant -> drop_cnt=1, dout=1 unchanged.
REQ-034 Full with simultaneous pop: level=8, grant sel=11 din3=32'h99 with out_ready=1 -> level stays 8, drop_cnt unchanged, 32'h99 emerges last.
REQ-035 Null select: en=1,sel=00 -> level stays 0, drop_cnt=1, word_cnt=0.
REQ-036 Wrap/order: 20 words 0..19 alternating sel 01/10/11, random out_ready -> output sequence 0..19 exact, word_cnt=20.
REQ-037 Reset mid-operation: level=5, assert rst_n=0 for 1 cycle with en pending -> level=0, dout_valid=0, counters 0, no push after release.
